// File: rtl/gb_host_initiator.sv
// gb_host_initiator: single-outstanding command initiator for a strobed host bus.
// Writes pulse GBPORT_wstb for one cycle. Reads pulse GBPORT_rstb, wait RLAT cycles,
// then capture GBPORT_din. Each response is held until rsp_ready.
// Optional feature: define GB_INITIATOR_BURST_EN to make a read of cmd_len=N fetch
// N+1 beats from consecutive addresses.
module gb_host_initiator #(
  parameter int unsigned AW   = 24,
  parameter int unsigned DW   = 32,
  parameter int unsigned RLAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [7:0]    cmd_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_last,
  output logic          busy,
  output logic          GBPORT_clk,
  output logic [AW-1:0] GBPORT_addr,
  output logic [DW-1:0] GBPORT_dout,
  input  logic [DW-1:0] GBPORT_din,
  output logic          GBPORT_we,
  output logic          GBPORT_wstb,
  output logic          GBPORT_rstb
);

  typedef enum logic [2:0] {StIdle, StWstb, StRstb, StRwait, StResp} state_e;

  // RWAIT lasts RLAT cycles; the counter is loaded with RLAT-1 and exits at zero.
  localparam logic [3:0] WaitInit = 4'(RLAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    wait_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] dout_q;
  logic [DW-1:0] rdata_q;
  logic          accept;
  logic          beat_last;

  assign accept = (state_q == StIdle) && cmd_valid;

`ifdef GB_INITIATOR_BURST_EN
  // Remaining beats after the current one; zero marks the final beat.
  logic [7:0] beats_q;
  assign beat_last = (beats_q == 8'd0);
`else
  logic unused_len;
  assign unused_len = ^cmd_len;
  assign beat_last  = 1'b1;
`endif

  // Bus clock is the system clock passed straight through.
  assign GBPORT_clk  = clk;
  assign GBPORT_addr = addr_q;
  assign GBPORT_dout = dout_q;
  // Strobes decode directly from state so reset removes them without waiting for an edge.
  assign GBPORT_wstb = (state_q == StWstb);
  assign GBPORT_we   = (state_q == StWstb);
  assign GBPORT_rstb = (state_q == StRstb);
  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_last    = (state_q == StResp) && beat_last;
  assign rsp_rdata   = rdata_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_valid) state_d = cmd_we ? StWstb : StRstb;
      StWstb:  state_d = StResp;
      StRstb:  state_d = StRwait;
      StRwait: if (wait_q == 4'd0) state_d = StResp;
      StResp:  if (rsp_ready) state_d = beat_last ? StIdle : StRstb;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: command capture, latency counter, read capture and burst stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      wait_q  <= '0;
`ifdef GB_INITIATOR_BURST_EN
      beats_q <= '0;
`endif
    end else begin
      if (accept) begin
        addr_q <= cmd_addr;
        dout_q <= cmd_wdata;
`ifdef GB_INITIATOR_BURST_EN
        beats_q <= cmd_we ? 8'd0 : cmd_len;
`endif
      end
      if (state_q == StWstb) rdata_q <= '0;
      if (state_q == StRstb) wait_q <= WaitInit;
      if (state_q == StRwait) begin
        if (wait_q == 4'd0) rdata_q <= GBPORT_din;
        else                wait_q  <= wait_q - 4'd1;
      end
`ifdef GB_INITIATOR_BURST_EN
      if ((state_q == StResp) && rsp_ready && !beat_last) begin
        beats_q <= beats_q - 8'd1;
        addr_q  <= addr_q + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gb_host_initiator.sv
// Self-checking bench for gb_host_initiator: directed commands, a latency-accurate
// bus responder, and a scoreboard monitor that checks every response handshake.
module tb_gb_host_initiator;

  localparam int unsigned AW   = 24;
  localparam int unsigned DW   = 32;
  localparam int unsigned RLAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [7:0]    cmd_len;
  logic          rsp_valid, rsp_ready, rsp_last, busy;
  logic [DW-1:0] rsp_rdata;
  logic          gb_clk, gb_we, gb_wstb, gb_rstb;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_dout, gb_din;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          last;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [AW-1:0] addr_log[$];

  gb_host_initiator #(.AW(AW), .DW(DW), .RLAT(RLAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .busy(busy),
    .GBPORT_clk(gb_clk), .GBPORT_addr(gb_addr), .GBPORT_dout(gb_dout),
    .GBPORT_din(gb_din), .GBPORT_we(gb_we), .GBPORT_wstb(gb_wstb), .GBPORT_rstb(gb_rstb)
  );

  always #5 clk = ~clk;

  // Responder data: 0x10 holds 0x42, every other address returns {A5, addr}.
  function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
    if (a == 24'h000010) return 32'h00000042;
    return {8'hA5, a};
  endfunction

  // Responder: din is valid only in the cycle exactly RLAT cycles after the rstb cycle.
  logic [15:0]   hist;
  logic [AW-1:0] ahist[16];
  always @(posedge clk) begin
    hist     <= {hist[14:0], gb_rstb};
    ahist[0] <= gb_addr;
    for (int i = 1; i < 16; i++) ahist[i] <= ahist[i-1];
  end
  assign gb_din = hist[RLAT-1] ? data_for(ahist[RLAT-1]) : 32'hBAD0BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and watches bus invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && (gb_wstb || gb_rstb)) begin
        bad++;
        $display("FAIL strobe_in_resp: wstb=%0b rstb=%0b", gb_wstb, gb_rstb);
      end
      if (gb_rstb) addr_log.push_back(gb_addr);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp: rdata=%0h with empty scoreboard", rsp_rdata);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_last", 64'(rsp_last), 64'(e.last));
        end
      end
    end
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!cmd_ready && n < bound) begin
      tick();
      n++;
    end
    check("idle_timeout", 64'(cmd_ready), 64'd1);
  endtask

  // Presents one command; returns in cycle T+1 with the command accepted at edge T.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [7:0] len);
    wait_idle(200);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    cmd_len   = 8'd0;
  endtask

  // Read with exact strobe and latency checks; caller has pushed the expectation.
  task automatic timed_read(input logic [AW-1:0] a, input logic [7:0] len);
    issue(1'b0, a, 32'h0, len);
    check("rd_rstb_t1", 64'(gb_rstb), 64'd1);
    check("rd_we_t1", 64'(gb_we), 64'd0);
    check("rd_addr_t1", 64'(gb_addr), 64'(a));
    for (int k = 2; k <= RLAT + 1; k++) begin
      tick();
      check("rd_wait_valid", 64'(rsp_valid), 64'd0);
      check("rd_wait_rstb", 64'(gb_rstb), 64'd0);
    end
    tick();
    check("rd_valid_t", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_len = 8'd0; rsp_ready = 1'b1;
    tick(); tick();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_addr", 64'(gb_addr), 64'd0);
    check("rst_dout", 64'(gb_dout), 64'd0);
    check("rst_strobes", 64'({gb_we, gb_wstb, gb_rstb}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Write 0x40 <- DEADBEEF; cmd_len must not matter for writes.
    exp_q.push_back('{rdata: 32'h0, last: 1'b1});
    issue(1'b1, 24'h000040, 32'hDEADBEEF, 8'h07);
    check("wr_wstb_t1", 64'(gb_wstb), 64'd1);
    check("wr_we_t1", 64'(gb_we), 64'd1);
    check("wr_rstb_t1", 64'(gb_rstb), 64'd0);
    check("wr_addr", 64'(gb_addr), 64'h40);
    check("wr_dout", 64'(gb_dout), 64'hDEADBEEF);
    check("wr_cmd_ready_t1", 64'(cmd_ready), 64'd0);
    check("wr_valid_t1", 64'(rsp_valid), 64'd0);
    tick();
    check("wr_wstb_t2", 64'(gb_wstb), 64'd0);
    check("wr_we_t2", 64'(gb_we), 64'd0);
    check("wr_valid_t2", 64'(rsp_valid), 64'd1);
    tick();
    check("wr_ready_after", 64'(cmd_ready), 64'd1);
    check("wr_dout_hold", 64'(gb_dout), 64'hDEADBEEF);

    // Read 0x10 -> 0x42 with exact latency.
    exp_q.push_back('{rdata: 32'h00000042, last: 1'b1});
    timed_read(24'h000010, 8'd0);
    tick();
    check("rd_ready_after", 64'(cmd_ready), 64'd1);

    // Read with rsp_ready held low for 10 cycles.
    rsp_ready = 1'b0;
    exp_q.push_back('{rdata: 32'hA5123456, last: 1'b1});
    timed_read(24'h123456, 8'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_rdata", 64'(rsp_rdata), 64'hA5123456);
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    check("hs_cycle_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("hs_next_cmd_ready", 64'(cmd_ready), 64'd1);
    check("hs_next_valid", 64'(rsp_valid), 64'd0);

`ifndef GB_INITIATOR_BURST_EN
    // Without bursts cmd_len is ignored: one response, last set.
    exp_q.push_back('{rdata: 32'hA5000077, last: 1'b1});
    timed_read(24'h000077, 8'd3);
    tick();
    check("nolen_ready", 64'(cmd_ready), 64'd1);
    check("nolen_addr", 64'(gb_addr), 64'h77);
`endif

    // Reset during RWAIT: no response ever comes back for that read.
    issue(1'b0, 24'h000020, 32'h0, 8'd0);
    check("rr_rstb_t1", 64'(gb_rstb), 64'd1);
    tick();
    check("rr_in_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rr_strobes", 64'({gb_we, gb_wstb, gb_rstb}), 64'd0);
    check("rr_busy", 64'(busy), 64'd0);
    check("rr_valid", 64'(rsp_valid), 64'd0);
    tick(); tick();
    rst = 1'b0;
    check("rr_addr_cleared", 64'(gb_addr), 64'd0);
    for (int k = 0; k < RLAT + 4; k++) begin
      tick();
      check("rr_no_rsp", 64'(rsp_valid), 64'd0);
      check("rr_idle", 64'(cmd_ready), 64'd1);
    end
    check("rr_sb_empty", 64'(exp_q.size()), 64'd0);

    // Normal operation after the reset.
    exp_q.push_back('{rdata: 32'h0, last: 1'b1});
    issue(1'b1, 24'h000080, 32'h12345678, 8'd0);
    check("post_wstb", 64'(gb_wstb), 64'd1);
    check("post_dout", 64'(gb_dout), 64'h12345678);
    exp_q.push_back('{rdata: 32'hA5000055, last: 1'b1});
    timed_read(24'h000055, 8'd0);

`ifdef GB_INITIATOR_BURST_EN
    // Three-beat burst wrapping through the top of the address space.
    wait_idle(50);
    addr_log.delete();
    exp_q.push_back('{rdata: 32'hA5FFFFFE, last: 1'b0});
    exp_q.push_back('{rdata: 32'hA5FFFFFF, last: 1'b0});
    exp_q.push_back('{rdata: 32'hA5000000, last: 1'b1});
    issue(1'b0, 24'hFFFFFE, 32'h0, 8'd2);
    tick();
    wait_idle(100);
    check("burst_strobes", 64'(addr_log.size()), 64'd3);
    if (addr_log.size() == 3) begin
      check("burst_a0", 64'(addr_log[0]), 64'hFFFFFE);
      check("burst_a1", 64'(addr_log[1]), 64'hFFFFFF);
      check("burst_a2", 64'(addr_log[2]), 64'h000000);
    end
    // Writes stay single-beat regardless of cmd_len.
    exp_q.push_back('{rdata: 32'h0, last: 1'b1});
    issue(1'b1, 24'h000100, 32'hCAFEF00D, 8'd4);
    tick(); tick();
    check("burst_wr_single", 64'(cmd_ready), 64'd1);
`endif

    wait_idle(100);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gb_host_initiator.md
GB_HOST_INITIATOR -- requirements
Module: gb_host_initiator

Interface
REQ-001 SHALL have parameter AW, default 24, bus address width.
REQ-002 SHALL have parameter DW, default 32, bus data width.
REQ-003 SHALL have parameter RLAT, default 2, legal 1..15: cycles from GBPORT_rstb to valid GBPORT_din.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_addr in AW, cmd_wdata in DW, cmd_len in 8 (extra read beats; burst feature only).
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out DW, rsp_last out 1, busy out 1.
REQ-008 SHALL have bus ports GBPORT_clk out 1, GBPORT_addr out AW, GBPORT_dout out DW, GBPORT_din in DW, GBPORT_we out 1, GBPORT_wstb out 1, GBPORT_rstb out 1.

Function
REQ-009 SHALL drive GBPORT_clk directly from clk (no logic, no register).
REQ-010 SHALL implement states IDLE, WSTB, RSTB, RWAIT, RESP; busy = (state != IDLE).
REQ-011 SHALL assert cmd_ready only in IDLE; a command is accepted on the edge where cmd_valid && cmd_ready.
REQ-012 SHALL register cmd_addr/cmd_wdata into GBPORT_addr/GBPORT_dout on accept; both hold value until the next accept.
REQ-013 SHALL, for write accepted at edge T: WSTB during cycle T+1 with GBPORT_wstb=1 and GBPORT_we=1 for exactly one cycle, then RESP with rsp_valid=1 from cycle T+2 and rsp_rdata=0.
REQ-014 SHALL, for read accepted at edge T: RSTB during cycle T+1 with GBPORT_rstb=1 for exactly one cycle and GBPORT_we=0; RWAIT counts RLAT-1 cycles; GBPORT_din sampled at end of cycle T+RLAT+1 into rsp_rdata; rsp_valid=1 from cycle T+RLAT+2.
REQ-015 SHALL keep GBPORT_we, GBPORT_wstb, GBPORT_rstb low in every state other than those named above.
REQ-016 SHALL hold rsp_valid, rsp_rdata, rsp_last stable in RESP until rsp_ready=1; no bus strobe issued while in RESP.
REQ-017 SHALL on response handshake of a final beat return to IDLE; cmd_ready rises the following cycle (never same-cycle re-accept).
REQ-018 SHALL present rsp_last=1 on every response when the burst feature is absent.

Reset
REQ-019 SHALL on rst asynchronously force state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_last=0, rsp_rdata=0, GBPORT_addr=0, GBPORT_dout=0, GBPORT_we=0, GBPORT_wstb=0, GBPORT_rstb=0, beat counter=0.
REQ-020 SHALL on reset mid-transaction drop strobes immediately and discard any pending response; no response is ever issued for that command.

Configuration
REQ-021 SHALL, with macro GB_INITIATOR_BURST_EN defined, treat a read with cmd_len=N as N+1 beats: after each beat's response handshake, GBPORT_addr increments by 1 (modulo 2^AW, all-ones wraps to 0) and flow restarts at RSTB; rsp_last=1 only on beat N+1.
REQ-022 SHALL, with GB_INITIATOR_BURST_EN defined, ignore cmd_len for writes (single beat, rsp_last=1).
REQ-023 SHALL, without GB_INITIATOR_BURST_EN, ignore cmd_len entirely and contain no beat counter.

Verification
REQ-024 Write addr=0x000040 data=0xDEADBEEF, rsp_ready=1 -> wstb/we high exactly one cycle at accept+1 with addr/dout as given; rsp_valid at accept+2, rdata=0, rsp_last=1.
REQ-025 Read addr=0x000010, RLAT=2, responder drives din=0x00000042 -> rstb one cycle at accept+1, rsp_valid at accept+4, rsp_rdata=0x00000042.
REQ-026 Read with rsp_ready held low 10 cycles -> rsp_valid/rsp_rdata stable 10 cycles, no further strobes, cmd_ready low; handshake then cmd_ready=1 next cycle.
REQ-027 BURST_EN, read addr=0xFFFFFE cmd_len=2 -> rstb at addresses 0xFFFFFE, 0xFFFFFF, 0x000000; three responses, rsp_last only on third.
REQ-028 Assert rst during RWAIT of a read -> strobes low immediately, rsp_valid never asserts, state IDLE, next command executes normally.
